// File: rtl/pipeline_defs.sv
// Definitions shared by the Decode/Execute pipeline blocks and hazard_control:
// forward-select encodings and the layout of the decoded-control bundle.
package pipeline_defs;

    localparam logic [1:0] NORMAL    = 2'b00;
    localparam logic [1:0] WRITEBACK = 2'b01;
    localparam logic [1:0] WRITEMEM  = 2'b10;

    localparam int CTRL_W_DEFAULT = 8;

    // Bit positions inside the decoded-control bundle.
    localparam int CTRL_ALU_OP_LSB = 0;
    localparam int CTRL_ALU_OP_W   = 4;
    localparam int CTRL_MEM_READ   = 4;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_BRANCH     = 6;
    localparam int CTRL_JUMP       = 7;

endpackage

// File: rtl/fwd_mux.sv
// One Execute-stage operand forwarding mux: picks registered data, the Memory
// stage ALU result or the Writeback result. The unused select code acts as NORMAL.
module fwd_mux
    import pipeline_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] reg_data,
    input  logic [XLEN-1:0] mem_data,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = reg_data;
        case (sel)
            WRITEMEM:  data = mem_data;
            WRITEBACK: data = wb_data;
            default:   data = reg_data;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-Execute pipeline register with Execute operand forwarding and a
// saturating counter of bubbles inserted by flush/stall.
module id_ex_stage
    import pipeline_defs::*;
#(
    parameter int XLEN   = 32,
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Dvalid,
    input  logic [4:0]        Dreg1_addr,
    input  logic [4:0]        Dreg2_addr,
    input  logic [XLEN-1:0]   Dreg1_data,
    input  logic [XLEN-1:0]   Dreg2_data,
    input  logic [XLEN-1:0]   Dimm,
    input  logic [XLEN-1:0]   Dpc,
    input  logic [4:0]        Dwrite_reg_addr,
    input  logic              Dwrite_reg_sig,
    input  logic [CTRL_W-1:0] Dctrl,
    input  logic              stallD,
    input  logic              flushE,
    input  logic [1:0]        forward1E,
    input  logic [1:0]        forward2E,
    input  logic [XLEN-1:0]   Malu_result,
    input  logic [XLEN-1:0]   Wresult,
    output logic              Evalid,
    output logic [4:0]        Ereg1_addr,
    output logic [4:0]        Ereg2_addr,
    output logic [XLEN-1:0]   Eop_a,
    output logic [XLEN-1:0]   Eop_b,
    output logic [XLEN-1:0]   Eimm,
    output logic [XLEN-1:0]   Epc,
    output logic [4:0]        Ewrite_reg_addr,
    output logic              Ewrite_reg_sig,
    output logic [CTRL_W-1:0] Ectrl,
    output logic [CNT_W-1:0]  bubble_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic              vld_p1;
    logic [4:0]        reg1_addr_p1;
    logic [4:0]        reg2_addr_p1;
    logic [XLEN-1:0]   reg1_data_p1;
    logic [XLEN-1:0]   reg2_data_p1;
    logic [XLEN-1:0]   imm_p1;
    logic [XLEN-1:0]   pc_p1;
    logic [4:0]        write_reg_addr_p1;
    logic              write_reg_sig_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [CNT_W-1:0]  bubble_cnt;
    logic              load_bubble;

    // Decode holds its instruction during a stall, so Execute must get a bubble
    // rather than a second copy.
    assign load_bubble = flushE | stallD;

    // ---- Decode -> Execute register boundary ----
    always_ff @(posedge clk) begin
        if (rst || load_bubble) begin
            vld_p1            <= 1'b0;
            reg1_addr_p1      <= '0;
            reg2_addr_p1      <= '0;
            reg1_data_p1      <= '0;
            reg2_data_p1      <= '0;
            imm_p1            <= '0;
            pc_p1             <= '0;
            write_reg_addr_p1 <= '0;
            write_reg_sig_p1  <= 1'b0;
            ctrl_p1           <= '0;
        end else begin
            vld_p1            <= Dvalid;
            reg1_addr_p1      <= Dreg1_addr;
            reg2_addr_p1      <= Dreg2_addr;
            reg1_data_p1      <= Dreg1_data;
            reg2_data_p1      <= Dreg2_data;
            imm_p1            <= Dimm;
            pc_p1             <= Dpc;
            write_reg_addr_p1 <= Dwrite_reg_addr;
            write_reg_sig_p1  <= Dwrite_reg_sig & Dvalid;
            ctrl_p1           <= Dctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (load_bubble) begin
            bubble_cnt <= sat_inc(bubble_cnt);
        end
    end

    // ---- Execute stage: combinational forwarding ----
    fwd_mux #(.XLEN(XLEN)) u_fwd_a (
        .sel      (forward1E),
        .reg_data (reg1_data_p1),
        .mem_data (Malu_result),
        .wb_data  (Wresult),
        .data     (Eop_a)
    );

    fwd_mux #(.XLEN(XLEN)) u_fwd_b (
        .sel      (forward2E),
        .reg_data (reg2_data_p1),
        .mem_data (Malu_result),
        .wb_data  (Wresult),
        .data     (Eop_b)
    );

    assign Evalid          = vld_p1;
    assign Ereg1_addr      = reg1_addr_p1;
    assign Ereg2_addr      = reg2_addr_p1;
    assign Eimm            = imm_p1;
    assign Epc             = pc_p1;
    assign Ewrite_reg_addr = write_reg_addr_p1;
    assign Ewrite_reg_sig  = write_reg_sig_p1;
    assign Ectrl           = ctrl_p1;
    assign bubble_count    = bubble_cnt;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- The Decode-to-Execute pipeline register and the Execute-stage operand forwarding muxes of the 5-stage core.
- Consumes the flush/stall and forward-select outputs of hazard_control, and returns the Execute source register addresses to it.
- Also counts inserted bubbles for performance debug.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 8, width of the opaque decoded-control bundle (alu_op, mem_read, mem_write, branch, ...).
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- Dvalid  input  1  Decode holds a real instruction.
- Dreg1_addr  input  5  rs1 address from Decode.
- Dreg2_addr  input  5  rs2 address from Decode.
- Dreg1_data  input  XLEN  register-file read data, rs1.
- Dreg2_data  input  XLEN  register-file read data, rs2.
- Dimm  input  XLEN  sign-extended immediate.
- Dpc  input  XLEN  instruction PC.
- Dwrite_reg_addr  input  5  destination register.
- Dwrite_reg_sig  input  1  instruction writes the register file.
- Dctrl  input  CTRL_W  decoded control bundle.
- stallD  input  1  Decode stalled by hazard_control.
- flushE  input  1  squash Execute (taken-branch shadow).
- forward1E  input  2  operand-A forward select.
- forward2E  input  2  operand-B forward select.
- Malu_result  input  XLEN  ALU result held in the Memory stage.
- Wresult  input  XLEN  result held in the Writeback stage.
- Evalid  output  1  Execute holds a real instruction.
- Ereg1_addr  output  5  registered rs1 address, to hazard_control.
- Ereg2_addr  output  5  registered rs2 address, to hazard_control.
- Eop_a  output  XLEN  forwarded operand A.
- Eop_b  output  XLEN  forwarded operand B (store data / ALU B before the immediate mux).
- Eimm  output  XLEN  registered immediate.
- Epc  output  XLEN  registered PC.
- Ewrite_reg_addr  output  5  registered destination register.
- Ewrite_reg_sig  output  1  registered write enable; gated by Evalid.
- Ectrl  output  CTRL_W  registered control bundle; all zero in a bubble.
- bubble_count  output  CNT_W  saturating count of bubbles inserted.

Behaviour:
- Register update each rising clk edge, in priority order:
  1. rst: load a bubble and clear bubble_count.
  2. flushE: load a bubble.
  3. stallD: load a bubble. Decode is holding, so the instruction must not enter Execute twice.
  4. Otherwise: capture all D* inputs, with Evalid <= Dvalid.
- Bubble contents: Evalid=0, Ewrite_reg_sig=0, Ectrl=0, Ereg1_addr=Ereg2_addr=Ewrite_reg_addr=0, Eimm=Epc=0, stored register data=0.
- Addresses are zeroed so hazard_control sees register 0 and never forwards into a bubble.
- Reset values: every output is 0.
- Latency: exactly one cycle from D* inputs to E* outputs. No multi-cycle hold in this block.
- bubble_count:
  - Increments by 1 on each cycle a bubble is loaded because of flushE or stallD, not rst.
  - A bubble caused by Dvalid=0 does not increment it.
  - Saturates at all-ones and does not wrap.
- Forwarding is combinational, from the registered register data and the current-cycle forward selects:
  - NORMAL: registered Dreg*_data.
  - WRITEMEM: Malu_result.
  - WRITEBACK: Wresult.
  - 2'b11: treated as NORMAL.
  - forward1E drives Eop_a; forward2E drives Eop_b. The two selects are fully independent.
- Simultaneous events:
  - flushE with stallD: a single bubble, counted once.
  - rst overrides everything.
- Reset mid-operation: an in-flight Execute instruction is discarded, and the next non-reset edge captures normally.

Decomposition:
- Shared package (pipeline_defs): forward-select constants NORMAL=2'b00, WRITEBACK=2'b01, WRITEMEM=2'b10. hazard_control uses the same definitions.
- Same package: a CTRL_W default and the bit positions inside Dctrl.
- Sub-module fwd_mux (one 3:1 XLEN mux with the select decode), instantiated twice.

Test Plan:
- Reset: rst high for 2 cycles with arbitrary D* inputs -> all outputs 0 and bubble_count=0. First edge after release captures Dreg1_addr=5, Dreg1_data=32'h11 -> Ereg1_addr=5, Eop_a=32'h11, Evalid=1.
- Pass-through: Dwrite_reg_addr=7, Dwrite_reg_sig=1, Dctrl=8'hA5 -> next cycle Ewrite_reg_addr=7, Ewrite_reg_sig=1, Ectrl=8'hA5. Check with Dvalid=0 -> Evalid=0, bubble_count unchanged.
- Forward selects: registered data 32'h1, Malu_result=32'h2, Wresult=32'h3. forward1E=WRITEMEM -> Eop_a=2. forward2E=WRITEBACK -> Eop_b=3. Select 2'b11 -> 1. Changing a select mid-cycle changes the output combinationally.
- Flush: flushE=1 for one cycle -> next cycle Evalid=0, Ewrite_reg_sig=0, Ereg1_addr=0, bubble_count=1.
- Stall with flush: stallD=1 for 2 cycles, one of them with flushE=1 -> two bubbles and bubble_count=2. Instruction held in Decode enters Execute exactly once after stallD drops.
- Saturation: preload by forcing or running 65535 flushes, then one more flush -> bubble_count stays 16'hFFFF.
